// File: rtl/uart_bus_pkg.sv
// Shared definitions for the MiniUART bus initiator: FSM encoding,
// default timeout and the slave's register word offsets.
package uart_bus_pkg;

    // Transaction FSM encoding
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUS  = 2'b01,
        ST_RESP = 2'b10
    } bus_state_t;

    // Cycles STB_O may stay high without ACK_I before aborting
    localparam int DEFAULT_TIMEOUT = 16;

    // MiniUART register word addresses (ADD[4:2])
    localparam logic [2:0] REG_DATA = 3'b000;
    localparam logic [2:0] REG_IER  = 3'b001;
    localparam logic [2:0] REG_IIR  = 3'b010;
    localparam logic [2:0] REG_LCR  = 3'b011;
    localparam logic [2:0] REG_LSR  = 3'b100;

    // Saturating increment used by the timeout counter
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/bus_timeout_ctr.sv
// Bus-cycle watchdog: counts cycles while enabled and raises a registered
// 'expired' flag while the count equals TIMEOUT-1. The count saturates, so
// it can never wrap back to a small value inside one transaction.
module bus_timeout_ctr #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;
    logic             expired_reg;
    logic             expired_next;

    // Next count: clear wins over enable; hold at all-ones instead of wrapping.
    // The flag is computed from the next count so that, once registered, it
    // is true exactly while count_reg == TIMEOUT-1.
    always_comb begin
        count_next = count_reg;
        if (clear) begin
            count_next = '0;
        end else if (enable && (count_reg != CNT_MAX)) begin
            count_next = count_reg + 1'b1;
        end
        expired_next = (count_next == CNT_LAST);
    end

    // Counter and flag registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_reg   <= '0;
            expired_reg <= 1'b0;
        end else begin
            count_reg   <= count_next;
            expired_reg <= expired_next;
        end
    end

    assign expired = expired_reg;

endmodule

// File: rtl/uart_bus_master.sv
// CPU-to-MiniUART bus initiator. A single-cycle CPU request is registered
// onto the strobe/acknowledge bus, held stable until ACK_I or timeout, and
// completed with a one-cycle cpu_ready_o pulse (cpu_err_o = timed out).
module uart_bus_master
    import uart_bus_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    parameter int CNT_W   = 8
) (
    input  logic        CLK_I,
    input  logic        RST_I,
    input  logic        cpu_req_i,
    input  logic        cpu_we_i,
    input  logic [2:0]  cpu_addr_i,
    input  logic [31:0] cpu_wdata_i,
    output logic        busy_o,
    output logic        cpu_ready_o,
    output logic        cpu_err_o,
    output logic [31:0] cpu_rdata_o,
    output logic [2:0]  ADD_O,
    output logic [31:0] DAT_O,
    input  logic [31:0] DAT_I,
    output logic        STB_O,
    output logic        WE_O,
    input  logic        ACK_I
);

    bus_state_t  state_reg, state_next;
    logic        stb_reg,   stb_next;
    logic        we_reg,    we_next;
    logic [2:0]  add_reg,   add_next;
    logic [31:0] dat_reg,   dat_next;
    logic        busy_reg,  busy_next;
    logic        ready_reg, ready_next;
    logic        err_reg,   err_next;
    logic [31:0] rdata_reg, rdata_next;

    logic ctr_clear;
    logic ctr_enable;
    logic timed_out;

    // Watchdog for the BUS phase; restarted whenever a request is accepted
    bus_timeout_ctr #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_timeout (
        .clk     (CLK_I),
        .rst_n   (RST_I),
        .clear   (ctr_clear),
        .enable  (ctr_enable),
        .expired (timed_out)
    );

    // Next-state and next-output logic; every output is a register so the
    // bus and CPU sides never see combinational paths through this block
    always_comb begin
        state_next = state_reg;
        stb_next   = stb_reg;
        we_next    = we_reg;
        add_next   = add_reg;
        dat_next   = dat_reg;
        busy_next  = busy_reg;
        ready_next = ready_reg;
        err_next   = err_reg;
        rdata_next = rdata_reg;
        ctr_clear  = 1'b0;
        ctr_enable = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                // ACK_I is deliberately not looked at here
                if (cpu_req_i) begin
                    we_next    = cpu_we_i;
                    add_next   = cpu_addr_i;
                    dat_next   = cpu_wdata_i;
                    stb_next   = 1'b1;
                    busy_next  = 1'b1;
                    ctr_clear  = 1'b1;
                    state_next = ST_BUS;
                end
            end

            ST_BUS: begin
                // Address, data and WE stay frozen; new CPU requests ignored
                ctr_enable = 1'b1;
                if (ACK_I) begin
                    // Acknowledge beats a simultaneous timeout
                    if (!we_reg) begin
                        rdata_next = DAT_I;
                    end
                    stb_next   = 1'b0;
                    we_next    = 1'b0;
                    ready_next = 1'b1;
                    err_next   = 1'b0;
                    state_next = ST_RESP;
                end else if (timed_out) begin
                    stb_next   = 1'b0;
                    we_next    = 1'b0;
                    ready_next = 1'b1;
                    err_next   = 1'b1;
                    state_next = ST_RESP;
                end
            end

            ST_RESP: begin
                // Completion pulse ends; err stays visible until next completion
                ready_next = 1'b0;
                busy_next  = 1'b0;
                state_next = ST_IDLE;
            end

            default: begin
                stb_next   = 1'b0;
                we_next    = 1'b0;
                busy_next  = 1'b0;
                ready_next = 1'b0;
                state_next = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge CLK_I) begin
        if (!RST_I) begin
            state_reg <= ST_IDLE;
            stb_reg   <= 1'b0;
            we_reg    <= 1'b0;
            add_reg   <= '0;
            dat_reg   <= '0;
            busy_reg  <= 1'b0;
            ready_reg <= 1'b0;
            err_reg   <= 1'b0;
            rdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            stb_reg   <= stb_next;
            we_reg    <= we_next;
            add_reg   <= add_next;
            dat_reg   <= dat_next;
            busy_reg  <= busy_next;
            ready_reg <= ready_next;
            err_reg   <= err_next;
            rdata_reg <= rdata_next;
        end
    end

    assign STB_O       = stb_reg;
    assign WE_O        = we_reg;
    assign ADD_O       = add_reg;
    assign DAT_O       = dat_reg;
    assign busy_o      = busy_reg;
    assign cpu_ready_o = ready_reg;
    assign cpu_err_o   = err_reg;
    assign cpu_rdata_o = rdata_reg;

endmodule

// File: doc/uart_bus_master.md
Name: uart_bus_master

Overview:
- Bus initiator that turns single-cycle CPU load/store requests into strobe/acknowledge transactions on the MiniUART-style slave bus.
- Bus signals: ADD[4:2], DAT in/out, STB, WE, ACK.
- Sits between the CPU data-memory stage and the UART slave.
- Registers each request, holds the bus stable until ACK or timeout, then returns a one-cycle completion to the CPU.

Parameters:
- TIMEOUT, 16: max cycles STB_O may stay high without ACK_I before the transaction aborts with error (legal range 2..255).
- CNT_W, 8: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- CLK_I  in  1  system clock; all logic on rising edge.
- RST_I  in  1  synchronous, active-low reset.
- cpu_req_i  in  1  request strobe; sampled only when busy_o=0.
- cpu_we_i  in  1  1 = write, 0 = read.
- cpu_addr_i  in  3  register word address [4:2].
- cpu_wdata_i  in  32  write data.
- busy_o  out  1  transaction in flight; CPU must stall.
- cpu_ready_o  out  1  one-cycle completion pulse.
- cpu_err_o  out  1  valid with cpu_ready_o; 1 = timed out.
- cpu_rdata_o  out  32  read data; valid with cpu_ready_o on reads.
- ADD_O  out  3  bus address [4:2].
- DAT_O  out  32  bus write data.
- DAT_I  in  32  bus read data.
- STB_O  out  1  bus strobe.
- WE_O  out  1  bus write enable.
- ACK_I  in  1  slave acknowledge.

Behaviour:
- Reset (RST_I=0 at a clock edge):
  - State IDLE.
  - STB_O=0, WE_O=0, ADD_O=0, DAT_O=0.
  - busy_o=0, cpu_ready_o=0, cpu_err_o=0, cpu_rdata_o=0, counter=0.
- All outputs are registered.
- States: IDLE, BUS, RESP.
- IDLE:
  - If cpu_req_i=1: latch we/addr/wdata into WE_O/ADD_O/DAT_O, set STB_O=1, busy_o=1, clear counter, go BUS.
  - Request at edge N gives STB_O high from edge N+1.
- BUS:
  - STB_O, WE_O, ADD_O, DAT_O held constant; counter increments each cycle.
  - If ACK_I=1:
    - On a read, capture DAT_I into cpu_rdata_o.
    - On a write, cpu_rdata_o is unchanged.
    - Set STB_O=0, WE_O=0, cpu_ready_o=1, cpu_err_o=0, go RESP.
  - Else if counter == TIMEOUT-1:
    - Set STB_O=0, WE_O=0, cpu_ready_o=1, cpu_err_o=1; cpu_rdata_o unchanged; go RESP.
  - ACK_I and the timeout in the same cycle: ACK wins, err=0.
- RESP:
  - cpu_ready_o=0, busy_o=0, go IDLE.
  - cpu_err_o holds until the next completion.
  - A cpu_req_i present in RESP is ignored; the CPU re-presents it once busy_o=0.
- Latency: ACK at edge K gives cpu_ready_o high during cycle K..K+1. Minimum request-to-ready is 2 cycles.
- ACK_I in IDLE or RESP is ignored (no state change, no data capture).
- cpu_req_i while busy_o=1 is ignored; no queueing.
- Reset mid-BUS: STB_O drops at that edge and no cpu_ready_o pulse is produced.
- Counter saturates; it never wraps within a transaction.

Decomposition:
- Shared package uart_bus_pkg holds:
  - state encoding (IDLE=2'b00, BUS=2'b01, RESP=2'b10);
  - DEFAULT_TIMEOUT=16;
  - MiniUART register offsets (DATA=3'b000, IER=3'b001, IIR=3'b010, LCR=3'b011, LSR=3'b100).
- One natural sub-module: bus_timeout_ctr.
  - Inputs: clear, enable.
  - Output: expired, registered compare against TIMEOUT-1.
- The FSM and data latches stay in the top.

Test Plan:
- Write: req we=1 addr=3'b000 wdata=0x41; slave ACKs 1 cycle after STB -> STB_O/WE_O=1 with ADD_O=0, DAT_O=0x41 held until ACK; ready=1 one cycle later, err=0.
- Read: req we=0 addr=3'b100; slave ACKs on 3rd STB cycle with DAT_I=0x00000060 -> cpu_rdata_o=0x60 with ready, busy_o low the following cycle.
- Timeout: TIMEOUT=16, slave never ACKs -> STB_O high exactly 16 cycles, then ready=1 with err=1 and cpu_rdata_o unchanged; next read with ACK gives err=0.
- Race: ACK_I arrives on the same cycle the counter hits TIMEOUT-1 with DAT_I=0x5A -> err=0, rdata=0x5A.
- Spurious and overlapping inputs:
  - ACK_I pulsed in IDLE -> no ready, rdata unchanged.
  - cpu_req_i held during BUS with different addr -> ADD_O stays at the latched value; the second request is taken only after busy_o=0.
- Reset mid-transaction: RST_I=0 on the 2nd STB cycle -> STB_O=0, busy_o=0, no ready pulse; ACK_I after reset is ignored.
